mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Sequences the shared 32-bit memory/MMIO bus (RAM, ROM, MMIO decode) between three requesters: debug unit, CPU data bus, CPU instruction bus.
- Replaces ad-hoc combinational muxing with a registered three-phase grant/issue/response machine, explicit per-requester handshakes and bounded instruction-fetch starvation.
- Sits between the dbgu32/VexRiscv bus adapters and the address decoder.

Parameters:
- STARVE_MAX, 4, max consecutive data grants while an instruction request waits before the instruction bus wins (1..15).

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- cpu_run  in  1  1 = CPU requesters eligible for grant; 0 = only debug served.
- dbg_req  in  1  debug request, held until dbg_ready.
- dbg_adr  in  32  debug byte address.
- dbg_di  in  32  debug write data.
- dbg_wren  in  4  debug byte write enables; 0 = read.
- dbg_ready  out  1  one-cycle command-accepted pulse.
- dbg_rvalid  out  1  one-cycle completion pulse; rdata valid.
- d_req, d_adr[32], d_di[32], d_wren[4]  in  CPU data request, same rules as debug.
- d_ready, d_rvalid  out  1  CPU data accept/completion pulses.
- i_req  in  1  CPU instruction fetch request.
- i_adr  in  32  fetch address.
- i_ready, i_rvalid  out  1  fetch accept/completion pulses.
- rdata  out  32  shared read data; meaningful only with an rvalid.
- mem_op  out  1  bus strobe to the decoder.
- mem_adr  out  32  bus address.
- mem_di  out  32  bus write data.
- mem_wren  out  4  bus byte enables.
- mem_do  in  32  OR-ed slave read data, valid the cycle after mem_op.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state): state=IDLE; mem_op, all ready and rvalid outputs = 0; mem_adr, mem_di, mem_wren, rdata = 0; owner=none; starve counter=0.
- IDLE:
  - Evaluate requests.
  - Priority: dbg > i (if starve counter == STARVE_MAX and i_req) > d > i.
  - d and i are eligible only when cpu_run=1.
  - On grant: pulse the winner's ready this cycle (combinational from the registered state plus the inputs), latch its adr/di/wren (i: wren=0, di=0) into the bus registers, record the owner, go to ISSUE.
  - No eligible request: stay in IDLE.
- ISSUE: mem_op=1 with the latched adr/di/wren for exactly one cycle; go to RESP.
- RESP:
  - Owner's rvalid=1 for one cycle; rdata=mem_do (combinational pass-through).
  - Writes also pulse rvalid as a write acknowledge; rdata is don't-care.
  - Then go to IDLE. mem_op=0, mem_wren=0.
- Timing: ready-to-rvalid latency is 2 cycles. Maximum throughput is one transfer per 3 cycles.
- Starve counter (4-bit, saturating at STARVE_MAX):
  - Increments on a d grant while i_req=1.
  - Clears on any i grant, or when i_req=0 in IDLE.
  - Debug grants do not change it.
- A requester must hold req/adr/di/wren stable until its ready pulse. Values after ready are ignored (command is latched).
- Dropping req before ready is legal; the request is then not served.
- cpu_run falling during ISSUE/RESP does not abort the transfer in flight. rvalid still pulses; the CPU-side clock gating is the top level's concern.
- Simultaneous dbg_req and d_req: dbg is granted. d_ready stays 0 and d waits for the next IDLE.
- mem_wren never nonzero outside ISSUE. No two ready pulses, and no two rvalid pulses, in the same cycle.
- Back-to-back requests from the same requester: the next grant is possible in the IDLE cycle immediately after RESP.

Test Plan:
- Reset mid-transfer: assert n_reset=0 asynchronously during ISSUE of a d write -> mem_op and mem_wren drop immediately, busy=0, no rvalid follows.
- Single read: dbg_req, dbg_adr=0x00020004, wren=0, mem_do=0xDEADBEEF in RESP -> dbg_ready at cycle 0, mem_op with mem_adr=0x00020004 at cycle 1, dbg_rvalid with rdata=0xDEADBEEF at cycle 2.
- Priority: dbg_req, d_req, i_req all asserted with cpu_run=1 -> grant order dbg, d, i. Each ready is spaced 3 cycles apart.
- Starvation: d_req and i_req held continuously, STARVE_MAX=4 -> grant pattern d,d,d,d,i repeating.
- cpu_run=0 with d_req and i_req held -> no d/i ready; a dbg_req still completes. Raising cpu_run -> d granted on the next IDLE.
- Write: d_req, d_adr=0x00010010, d_di=0x55, d_wren=4'b0001 -> ISSUE drives mem_wren=0001 and mem_di=0x55 for exactly one cycle; d_rvalid pulses at cycle 2.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Three-phase (grant / issue / response) arbiter for the shared memory/MMIO bus.
// Requesters: debug unit, CPU data bus, CPU instruction bus with bounded fetch starvation.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cpu_run,
  input  logic        dbg_req,
  input  logic [31:0] dbg_adr,
  input  logic [31:0] dbg_di,
  input  logic [3:0]  dbg_wren,
  output logic        dbg_ready,
  output logic        dbg_rvalid,
  input  logic        d_req,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_di,
  input  logic [3:0]  d_wren,
  output logic        d_ready,
  output logic        d_rvalid,
  input  logic        i_req,
  input  logic [31:0] i_adr,
  output logic        i_ready,
  output logic        i_rvalid,
  output logic [31:0] rdata,
  output logic        mem_op,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_di,
  output logic [3:0]  mem_wren,
  input  logic [31:0] mem_do,
  output logic        busy
);

  // state | meaning
  // IDLE  | evaluate requests, pulse winner's ready, latch its command
  // ISSUE | drive mem_op with the latched command for one cycle
  // RESP  | pulse owner's rvalid, pass mem_do through to rdata
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_DBG, OWN_D, OWN_I} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state, state_nxt;
  owner_t      owner, grant;
  logic [3:0]  starve;
  logic [3:0]  wren_q;

  always_comb begin
    grant = OWN_NONE;
    if (state == IDLE) begin
      if (dbg_req)                                        grant = OWN_DBG;
      else if (cpu_run && i_req && starve == STARVE_LIM)  grant = OWN_I;
      else if (cpu_run && d_req)                          grant = OWN_D;
      else if (cpu_run && i_req)                          grant = OWN_I;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant != OWN_NONE) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dbg_ready  = (grant == OWN_DBG);
    d_ready    = (grant == OWN_D);
    i_ready    = (grant == OWN_I);
    dbg_rvalid = (state == RESP) && (owner == OWN_DBG);
    d_rvalid   = (state == RESP) && (owner == OWN_D);
    i_rvalid   = (state == RESP) && (owner == OWN_I);
    mem_op     = (state == ISSUE);
    mem_wren   = (state == ISSUE) ? wren_q : 4'h0;
    rdata      = (state == RESP) ? mem_do : 32'h0;
    busy       = (state != IDLE);
  end

  // Command latch; fetches are always reads with zero write data.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      owner   <= OWN_NONE;
      mem_adr <= 32'h0;
      mem_di  <= 32'h0;
      wren_q  <= 4'h0;
    end else begin
      case (grant)
        OWN_DBG: begin
          owner <= OWN_DBG; mem_adr <= dbg_adr; mem_di <= dbg_di; wren_q <= dbg_wren;
        end
        OWN_D: begin
          owner <= OWN_D; mem_adr <= d_adr; mem_di <= d_di; wren_q <= d_wren;
        end
        OWN_I: begin
          owner <= OWN_I; mem_adr <= i_adr; mem_di <= 32'h0; wren_q <= 4'h0;
        end
        default: ;
      endcase
    end
  end

  // Counts data grants that overtook a waiting fetch; debug grants leave it alone.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      starve <= 4'h0;
    end else if (state == IDLE) begin
      if (grant == OWN_I || !i_req)
        starve <= 4'h0;
      else if (grant == OWN_D && starve != STARVE_LIM)
        starve <= starve + 4'h1;
    end
  end

endmodule
